reg_bank_write_port: RTL
========================

Name: reg_bank_write_port

Overview:
- Write side of the 16 x 32-bit ARM register bank; the 16:1 read multiplexers sit on its flattened output bus.
- Decodes a 4-bit destination index into one-hot load enables and captures write data on the clock edge.
- Holds R15 (PC) with an auto-increment path.
- Exports all 16 registers continuously to the read-port muxes.

Parameters:
- DATA_W, 32, register width in bits.
- PC_RESET, 32'h0000_0000, R15 value after reset.
- PC_STEP, 4, R15 increment applied when pc_inc is asserted.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write request for port A.
- wr_sel  input  4  port A destination register index (0..15).
- wr_data  input  DATA_W  port A write data.
- pc_inc  input  1  advance R15 by PC_STEP this cycle.
- dec_en  output  16  one-hot decoded load enables, combinational from wr_en/wr_sel (all 0 when wr_en=0).
- regs_q  output  16*DATA_W  flattened bank; Rn occupies bits [n*DATA_W +: DATA_W].
- pc_q  output  DATA_W  copy of R15, equal to regs_q[15*DATA_W +: DATA_W].
- wr_ack  output  1  registered; high for exactly one cycle after any accepted port A write.

Behaviour:
- Reset (rst_n low, asynchronous): R0..R14 = 0, R15 = PC_RESET, wr_ack = 0.
  - Reset asserted mid-write aborts the write; no partial update.
  - First edge after deassertion operates normally.
- Decoder: dec_en[k] = wr_en & (wr_sel == k).
  - Exactly one bit is high when wr_en=1; all bits low otherwise.
- Write latency: a write presented at edge N is visible on regs_q/pc_q immediately after edge N; one cycle, no internal bypass.
- wr_ack is set at edge N when wr_en=1, and cleared at edge N+1 unless another write occurs. Back-to-back writes hold wr_ack high continuously.
- R15 update priority each edge:
  1. Port A write to R15.
  2. DUAL_WRITE_EN port B write to R15 (see Optional Feature).
  3. pc_inc: R15 <= R15 + PC_STEP.
  4. Hold.
- PC arithmetic: modulo 2^DATA_W; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
- Write to R15 together with pc_inc: the written value wins; the increment is dropped that cycle.
- Write to Rn (n≠15) together with pc_inc: both take effect in the same edge.
- wr_sel changing while wr_en=0: no state change.
- X on wr_sel while wr_en=1 is a bench error and is flagged by an assertion in simulation.

Optional Feature:
- Macro: REG_BANK_DUAL_WRITE_EN.
- Defined: adds a second write port for base-register writeback (LDR/STR with writeback).
  - New ports: wb_en (1), wb_sel (4), wb_data (DATA_W).
  - A second decoder drives the internal enables for port B.
  - If wb_sel == wr_sel with both enables high, port A wins and port B is discarded.
  - A port B write to R15 beats pc_inc.
  - wr_ack reflects port A only.
- Undefined: the port B ports do not exist; the bank behaves as single-write.

Decomposition:
- Shared definitions header arm_defs.vh holds:
  - REG_COUNT = 16
  - REG_IDX_W = 4
  - PC_IDX = 15
  - WORD_W = 32
  - PC_STEP default
- Sub-module decoder_4x16: inputs en and sel[3:0], output one-hot [15:0].
  - Instantiated once, or twice with REG_BANK_DUAL_WRITE_EN.
  - Also reused by other control logic.
- Register array, PC priority logic and wr_ack live in reg_bank_write_port.

Test Plan:
- Reset check: hold rst_n=0, drive wr_en=1 / wr_sel=3 / wr_data=32'hDEAD_BEEF, then release -> all regs 0, pc_q = PC_RESET, wr_ack = 0, R3 stays 0.
- Walking write: for i = 0..15, write wr_data = i at wr_sel = i, one per cycle -> after each edge Ri = i and dec_en = (1<<i); after the sweep regs_q reads 0..15 in order; wr_ack stays high throughout.
- PC increment and wrap: load R15 = 32'hFFFF_FFF8, then pc_inc for 3 cycles -> FFFF_FFFC, 0000_0000, 0000_0004.
- Collision: pc_inc=1 with a write to R15 of 32'h0000_1000 -> pc_q = 32'h0000_1000. Same cycle with a write to R2 = 7 instead -> R2 = 7 and R15 advances by 4.
- Mid-operation reset: assert rst_n low asynchronously between edges during a write burst -> outputs go to reset values immediately, without waiting for a clock edge.
- REG_BANK_DUAL_WRITE_EN:
  - wr_sel = wb_sel = 5 with wr_data = 1, wb_data = 2 -> R5 = 1.
  - wr_sel = 5, wb_sel = 6 -> R5 = 1 and R6 = 2 on the same edge.

Source files
------------

// File: rtl/reg_bank_write_port_pkg.sv
// Shared register-bank definitions: bank geometry, PC index and the index-to-one-hot helper.
package reg_bank_write_port_pkg;
  localparam int REG_COUNT       = 16;
  localparam int REG_IDX_W       = 4;
  localparam int PC_IDX          = 15;
  localparam int WORD_W          = 32;
  localparam int PC_STEP_DEFAULT = 4;

  function automatic logic [REG_COUNT-1:0] onehot_idx(input logic en, input logic [REG_IDX_W-1:0] sel);
    onehot_idx = '0;
    if (en) onehot_idx[sel] = 1'b1;
  endfunction
endpackage

// File: rtl/reg_bank_write_port_decoder_4x16.sv
// 4-to-16 one-hot decoder gated by an enable; purely combinational, no backpressure.
module decoder_4x16
  import reg_bank_write_port_pkg::*;
(
  input  logic                 en,
  input  logic [REG_IDX_W-1:0] sel,
  output logic [REG_COUNT-1:0] dec
);

  always_comb begin
    dec = onehot_idx(en, sel);
  end

endmodule

// File: rtl/reg_bank_write_port.sv
// Write side of the 16 x DATA_W bank with R15 auto-increment; writes land one edge after request, never stalled.
// REG_BANK_DUAL_WRITE_EN adds write port B (base-register writeback), port A wins collisions.
module reg_bank_write_port
  import reg_bank_write_port_pkg::*;
#(
  parameter int                DATA_W   = WORD_W,
  parameter logic [DATA_W-1:0] PC_RESET = '0,
  parameter int                PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [REG_IDX_W-1:0]        wr_sel,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic                        pc_inc,
`ifdef REG_BANK_DUAL_WRITE_EN
  input  logic                        wb_en,
  input  logic [REG_IDX_W-1:0]        wb_sel,
  input  logic [DATA_W-1:0]           wb_data,
`endif
  output logic [REG_COUNT-1:0]        dec_en,
  output logic [REG_COUNT*DATA_W-1:0] regs_q,
  output logic [DATA_W-1:0]           pc_q,
  output logic                        wr_ack
);

  logic [DATA_W-1:0]    bank_q [REG_COUNT];
  logic [DATA_W-1:0]    bank_d [REG_COUNT];
  logic [REG_COUNT-1:0] dec_b;
  logic [DATA_W-1:0]    wb_data_w;
  logic                 ack_q;

  decoder_4x16 u_dec_a (
    .en  (wr_en),
    .sel (wr_sel),
    .dec (dec_en)
  );

`ifdef REG_BANK_DUAL_WRITE_EN
  decoder_4x16 u_dec_b (
    .en  (wb_en),
    .sel (wb_sel),
    .dec (dec_b)
  );
  assign wb_data_w = wb_data;
`else
  assign dec_b     = '0;
  assign wb_data_w = '0;
`endif

  // Per-register priority: port A, then port B, then (R15 only) the PC increment.
  always_comb begin
    for (int n = 0; n < REG_COUNT; n++) begin
      bank_d[n] = bank_q[n];
      if (dec_en[n]) begin
        bank_d[n] = wr_data;
      end else if (dec_b[n]) begin
        bank_d[n] = wb_data_w;
      end else if ((n == PC_IDX) && pc_inc) begin
        bank_d[n] = bank_q[n] + DATA_W'(PC_STEP);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < REG_COUNT; n++) begin
        bank_q[n] <= (n == PC_IDX) ? PC_RESET : '0;
      end
      ack_q <= 1'b0;
    end else begin
      bank_q <= bank_d;
      ack_q  <= wr_en;
    end
  end

  always_comb begin
    for (int n = 0; n < REG_COUNT; n++) begin
      regs_q[n*DATA_W +: DATA_W] = bank_q[n];
    end
  end

  assign pc_q   = bank_q[PC_IDX];
  assign wr_ack = ack_q;

  a_wr_sel_known: assert property (@(posedge clk) disable iff (!rst_n) wr_en |-> !$isunknown(wr_sel));

endmodule
